bounce_engine: RTL and testbench

Parametrised motion generator for the screen-saver logo. It produces the top-left (x, y) position of a rectangular object that bounces inside a configurable screen area. It adds runtime speed control, pause/restart, per-axis hit events and a sound-request interface for the audio block. It sits between the video timing / renderer (which consumes `x_logo`/`y_logo`) and the sound generator (which consumes `code_sound`/`mute`). Everything runs on one clock domain with clock-enable strobes; no derived clocks.

---
 rtl/bounce_engine.sv | 191 +++++++++++++++++++
 tb/tb_bounce_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_engine.sv
// bounce_engine: screen-saver logo motion generator with speed control,
// pause/restart, per-axis hit pulses and sound requests.
module bounce_engine #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int OBJ_W    = 80,
    parameter int OBJ_H    = 96,
    parameter int BORDER   = 0,
    parameter int CW       = 10,
    parameter int STEP_X   = 1,
    parameter int STEP_Y   = 2,
    parameter int CNT_W    = 32,
    parameter int DLY_MIN  = 0,
    parameter int DLY_MAX  = 24,
    parameter int DLY_INIT = 16,
    parameter int SND_LEN  = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          inc_vel,
    input  logic          dec_vel,
    input  logic          pause,
    input  logic          restart,
    output logic [CW-1:0] x_logo,
    output logic [CW-1:0] y_logo,
    output logic          dir_x,
    output logic          dir_y,
    output logic          hit_x,
    output logic          hit_y,
    output logic [4:0]    delay,
    output logic          mute,
    output logic [1:0]    code_sound
);

    localparam int TW = $clog2(SND_LEN + 1);

    localparam logic [CW-1:0] X_C = CW'((H_RES - OBJ_W) / 2);
    localparam logic [CW-1:0] Y_C = CW'((V_RES - OBJ_H) / 2);

    localparam logic [CW:0] X_LO = (CW+1)'(BORDER);
    localparam logic [CW:0] X_HI = (CW+1)'(H_RES - OBJ_W - BORDER);
    localparam logic [CW:0] Y_LO = (CW+1)'(BORDER);
    localparam logic [CW:0] Y_HI = (CW+1)'(V_RES - OBJ_H - BORDER);
    localparam logic [CW:0] SX   = (CW+1)'(STEP_X);
    localparam logic [CW:0] SY   = (CW+1)'(STEP_Y);

    localparam logic [4:0]    D_MIN  = 5'(DLY_MIN);
    localparam logic [4:0]    D_MAX  = 5'(DLY_MAX);
    localparam logic [4:0]    D_INIT = 5'(DLY_INIT);
    localparam logic [TW-1:0] T_LEN  = TW'(SND_LEN);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] mask;
    logic             upd;
    logic             mv;
    logic             inc_q;
    logic             dec_q;
    logic             inc_rise;
    logic             dec_rise;
    logic [4:0]       delay_nxt;
    logic [TW-1:0]    snd_t;

    logic [CW-1:0]    x_nxt;
    logic [CW-1:0]    y_nxt;
    logic             dx_nxt;
    logic             dy_nxt;
    logic             hx;
    logic             hy;

    // Result packed as {hit, dir, pos}; compares run one bit wider than CW.
    function automatic logic [CW+1:0] step_axis(
        input logic [CW-1:0] p,
        input logic          d,
        input logic [CW:0]   s,
        input logic [CW:0]   lo,
        input logic [CW:0]   hi
    );
        logic [CW:0] pe;
        logic [CW:0] fwd;
        logic [CW:0] bwd;
        pe  = {1'b0, p};
        fwd = pe + s;
        bwd = pe - s;
        if (d) begin
            if (fwd > hi)
                step_axis = {1'b1, 1'b0, hi[CW-1:0]};
            else
                step_axis = {1'b0, 1'b1, fwd[CW-1:0]};
        end else begin
            if (pe < lo + s)
                step_axis = {1'b1, 1'b1, lo[CW-1:0]};
            else
                step_axis = {1'b0, 1'b0, bwd[CW-1:0]};
        end
    endfunction

    // Prescaler strobe: low `delay` bits of the counter all ones.
    assign mask = ~({CNT_W{1'b1}} << delay);
    assign upd  = &(cnt | ~mask);
    assign mv   = upd & ~pause;

    assign inc_rise = inc_vel & ~inc_q;
    assign dec_rise = dec_vel & ~dec_q;

    always_comb begin
        delay_nxt = delay;
        unique case (1'b1)
            inc_rise & ~dec_rise:
                if (delay > D_MIN) delay_nxt = delay - 5'd1;
            dec_rise & ~inc_rise:
                if (delay < D_MAX) delay_nxt = delay + 5'd1;
            default: delay_nxt = delay;
        endcase
    end

    always_comb begin
        {hx, dx_nxt, x_nxt} = step_axis(x_logo, dir_x, SX, X_LO, X_HI);
        {hy, dy_nxt, y_nxt} = step_axis(y_logo, dir_y, SY, Y_LO, Y_HI);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt   <= '0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            delay <= D_INIT;
        end else begin
            cnt   <= cnt + 1'b1;
            inc_q <= inc_vel;
            dec_q <= dec_vel;
            delay <= delay_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            x_logo <= X_C;
            y_logo <= Y_C;
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
            hit_x  <= 1'b0;
            hit_y  <= 1'b0;
        end else if (restart) begin
            x_logo <= X_C;
            y_logo <= Y_C;
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
            hit_x  <= 1'b0;
            hit_y  <= 1'b0;
        end else if (mv) begin
            x_logo <= x_nxt;
            y_logo <= y_nxt;
            dir_x  <= dx_nxt;
            dir_y  <= dy_nxt;
            hit_x  <= hx;
            hit_y  <= hy;
        end else begin
            hit_x  <= 1'b0;
            hit_y  <= 1'b0;
        end
    end

    // Any hit retriggers the sound; hit-free updates count it down.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mute       <= 1'b1;
            code_sound <= 2'b00;
            snd_t      <= '0;
        end else if (restart) begin
            mute       <= 1'b0;
            code_sound <= 2'b11;
            snd_t      <= T_LEN;
        end else if (mv) begin
            if (hx | hy) begin
                mute  <= 1'b0;
                snd_t <= T_LEN;
                if (hx & hy)
                    code_sound <= 2'b11;
                else if (hx)
                    code_sound <= 2'b01;
                else
                    code_sound <= 2'b10;
            end else if (snd_t != '0) begin
                snd_t <= snd_t - 1'b1;
                if (snd_t == TW'(1))
                    mute <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bounce_engine.sv
// Directed bench for bounce_engine: motion, reflections, sound,
// speed control, pause, restart and asynchronous clear.
module tb_bounce_engine;

    logic clk = 1'b0;
    logic clr_n = 1'b0;

    logic a_inc = 0, a_dec = 0, a_pause = 0, a_restart = 0;
    logic [9:0] a_x, a_y;
    logic a_dx, a_dy, a_hx, a_hy, a_mute;
    logic [4:0] a_delay;
    logic [1:0] a_code;

    logic c_inc = 0, c_dec = 0, c_pause = 0, c_restart = 0;
    logic [9:0] c_x, c_y;
    logic c_dx, c_dy, c_hx, c_hy, c_mute;
    logic [4:0] c_delay;
    logic [1:0] c_code;

    logic s_inc = 0, s_dec = 0, s_pause = 0, s_restart = 0;
    logic [9:0] s_x, s_y;
    logic s_dx, s_dy, s_hx, s_hy, s_mute;
    logic [4:0] s_delay;
    logic [1:0] s_code;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bounce_engine #(.DLY_INIT(0)) dut_a (
        .clk(clk), .clr_n(clr_n), .inc_vel(a_inc), .dec_vel(a_dec),
        .pause(a_pause), .restart(a_restart), .x_logo(a_x), .y_logo(a_y),
        .dir_x(a_dx), .dir_y(a_dy), .hit_x(a_hx), .hit_y(a_hy),
        .delay(a_delay), .mute(a_mute), .code_sound(a_code)
    );

    bounce_engine #(
        .H_RES(100), .V_RES(100), .OBJ_W(20), .OBJ_H(20),
        .STEP_X(1), .STEP_Y(1), .DLY_INIT(0)
    ) dut_c (
        .clk(clk), .clr_n(clr_n), .inc_vel(c_inc), .dec_vel(c_dec),
        .pause(c_pause), .restart(c_restart), .x_logo(c_x), .y_logo(c_y),
        .dir_x(c_dx), .dir_y(c_dy), .hit_x(c_hx), .hit_y(c_hy),
        .delay(c_delay), .mute(c_mute), .code_sound(c_code)
    );

    bounce_engine #(.DLY_INIT(4)) dut_s (
        .clk(clk), .clr_n(clr_n), .inc_vel(s_inc), .dec_vel(s_dec),
        .pause(s_pause), .restart(s_restart), .x_logo(s_x), .y_logo(s_y),
        .dir_x(s_dx), .dir_y(s_dy), .hit_x(s_hx), .hit_y(s_hy),
        .delay(s_delay), .mute(s_mute), .code_sound(s_code)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        tick(2);
        clr_n = 1'b1;
    endtask

    // Clocks between two successive x changes of dut_s.
    task automatic s_period(output int p);
        logic [9:0] x0;
        int c;
        x0 = s_x;
        c = 0;
        while (s_x == x0 && c < 100) begin
            tick(1);
            c++;
        end
        x0 = s_x;
        c = 0;
        while (s_x == x0 && c < 100) begin
            tick(1);
            c++;
        end
        p = c;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        logic [9:0] xh, yh;

        tick(1);
        chk("rst_x", a_x, 280);
        chk("rst_y", a_y, 192);
        chk("rst_dir", {a_dx, a_dy}, 2'b11);
        chk("rst_hit", {a_hx, a_hy}, 2'b00);
        chk("rst_mute", a_mute, 1);
        chk("rst_code", a_code, 0);
        chk("rst_delay", a_delay, 0);
        chk("rst_s_delay", s_delay, 4);
        clr_n = 1'b1;

        // Counted from release: k posedges => k updates at delay 0.
        for (int k = 1; k <= 290; k++) begin
            tick(1);
            if (k == 1) begin
                chk("first_x", a_x, 281);
                chk("first_y", a_y, 194);
            end
            if (k == 40) begin
                chk("c40_x", c_x, 80);
                chk("c40_y", c_y, 80);
                chk("c40_hit", {c_hx, c_hy}, 2'b00);
            end
            if (k == 41) begin
                chk("c41_x", c_x, 80);
                chk("c41_hit", {c_hx, c_hy}, 2'b11);
                chk("c41_dir", {c_dx, c_dy}, 2'b00);
                chk("c41_code", c_code, 3);
                chk("c41_mute", c_mute, 0);
            end
            if (k == 96) begin
                chk("y96", a_y, 384);
                chk("y96_hit", a_hy, 0);
            end
            if (k == 97) begin
                chk("y97", a_y, 384);
                chk("y97_dir", a_dy, 0);
                chk("y97_hit", a_hy, 1);
                chk("y97_code", a_code, 2);
                chk("y97_mute", a_mute, 0);
                chk("y97_x", a_x, 377);
            end
            if (k == 98) begin
                chk("y98_hit", a_hy, 0);
                chk("y98", a_y, 382);
            end
            if (k == 280) begin
                chk("x280", a_x, 560);
                chk("x280_dir", a_dx, 1);
            end
            if (k == 281) begin
                chk("x281", a_x, 560);
                chk("x281_dir", a_dx, 0);
                chk("x281_hit", a_hx, 1);
                chk("x281_code", a_code, 1);
                chk("x281_mute", a_mute, 0);
            end
            if (k == 282) begin
                chk("x282", a_x, 559);
                chk("x282_hit", a_hx, 0);
            end
            if (k == 288) chk("mute7", a_mute, 0);
            if (k == 289) begin
                chk("mute8", a_mute, 1);
                chk("code_hold", a_code, 1);
                chk("y289", a_y, 0);
            end
            if (k == 290) begin
                chk("y290_hit", a_hy, 1);
                chk("y290_code", a_code, 2);
            end
        end

        // Asynchronous clear between edges.
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("aclr_x", a_x, 280);
        chk("aclr_y", a_y, 192);
        chk("aclr_mute", a_mute, 1);
        chk("aclr_code", a_code, 0);
        chk("aclr_dir", {a_dx, a_dy}, 2'b11);
        tick(1);
        clr_n = 1'b1;
        tick(50);
        chk("pre_rst_x", a_x, 330);
        a_restart = 1'b1;
        tick(1);
        a_restart = 1'b0;
        chk("rs_x", a_x, 280);
        chk("rs_y", a_y, 192);
        chk("rs_code", a_code, 3);
        chk("rs_mute", a_mute, 0);
        tick(1);
        chk("rs_next_x", a_x, 281);

        // Speed control on the DLY_INIT=4 instance.
        do_reset();
        tick(15);
        chk("s15_x", s_x, 280);
        tick(1);
        chk("s16_x", s_x, 281);
        s_period(p);
        chk("s_period16", p, 16);
        s_inc = 1'b1;
        tick(1);
        chk("s_inc_1clk", s_delay, 3);
        tick(99);
        chk("s_inc_hold", s_delay, 3);
        s_period(p);
        chk("s_period8", p, 8);
        s_inc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            s_dec = 1'b1;
            tick(1);
            s_dec = 1'b0;
            tick(1);
        end
        chk("s_dly_max", s_delay, 24);
        for (int i = 0; i < 25; i++) begin
            s_inc = 1'b1;
            tick(1);
            s_inc = 1'b0;
            tick(1);
        end
        chk("s_dly_min", s_delay, 0);
        s_dec = 1'b1;
        tick(1);
        chk("s_dec_one", s_delay, 1);
        s_dec = 1'b0;
        tick(1);
        s_inc = 1'b1;
        s_dec = 1'b1;
        tick(1);
        chk("s_both", s_delay, 1);
        s_dec = 1'b0;
        tick(1);
        s_inc = 1'b0;
        tick(1);
        s_inc = 1'b1;
        tick(1);
        s_inc = 1'b0;
        chk("s_back0", s_delay, 0);

        xh = s_x;
        yh = s_y;
        s_pause = 1'b1;
        tick(5);
        chk("pause_x", s_x, xh);
        chk("pause_y", s_y, yh);
        chk("pause_hit", {s_hx, s_hy}, 2'b00);
        s_pause = 1'b0;
        tick(1);
        chk("unpause_x", s_x, xh + 10'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
